gp_cmd_decoder: RTL

Graphics-processor command decoder sitting directly downstream of the GP command-word FIFO. It consumes the 32-bit command stream the FIFO fetches from DRAM, assembles multi-word FILL and LINE commands, clamps and normalizes coordinates, and hands each command to the drawing engines over a valid/ready handshake. It back-pressures the FIFO through `GP_stall` and ends the stream with `GP_interrupt` on STOP or on an illegal opcode.

---
 rtl/gp_cmd_decoder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/gp_cmd_decoder.sv
// gp_cmd_decoder
//
// Sits downstream of the GP command-word FIFO. It assembles the three-word FILL
// and LINE commands (header, ARG1, ARG2), clamps the coordinates, and orders
// FILL corners so that x0 <= x1 and y0 <= y1. Each finished command goes to the
// drawing engines over a valid/ready handshake. A STOP word or an illegal
// opcode ends the stream with a one-cycle GP_interrupt.
//
// Ports
//   clk            : clock; all state changes on the rising edge
//   rst            : asynchronous reset, active low
//   GP_valid       : one-cycle pulse that starts a new command stream
//   fifo_GP_out    : current command word from the FIFO
//   fifo_stall     : 1 when fifo_GP_out is not valid this cycle
//   GP_stall       : 1 tells the FIFO to hold its read pointer
//   GP_interrupt   : one-cycle pulse that ends the stream
//   cmd_valid      : a command is presented to the drawing engines
//   cmd_ready      : the engine accepts the presented command
//   cmd_type       : 0 = FILL, 1 = LINE
//   cmd_color      : 24-bit RGB color
//   cmd_x0..cmd_y1 : endpoint coordinates
//   cmd_count      : number of commands accepted since the last GP_valid
//   err            : sticky illegal-opcode flag
module gp_cmd_decoder #(
    parameter int unsigned XMAX = 799,
    parameter int unsigned YMAX = 599
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        GP_valid,
    input  logic [31:0] fifo_GP_out,
    input  logic        fifo_stall,
    output logic        GP_stall,
    output logic        GP_interrupt,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_type,
    output logic [23:0] cmd_color,
    output logic [9:0]  cmd_x0,
    output logic [9:0]  cmd_y0,
    output logic [9:0]  cmd_x1,
    output logic [9:0]  cmd_y1,
    output logic [15:0] cmd_count,
    output logic        err
);

    localparam logic [7:0] OpStop = 8'h00;
    localparam logic [7:0] OpFill = 8'h01;
    localparam logic [7:0] OpLine = 8'h02;

    localparam logic [9:0] XMaxC = 10'(XMAX);
    localparam logic [9:0] YMaxC = 10'(YMAX);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StArg1,
        StArg2,
        StIssue,
        StDone,
        StErr
    } state_e;

    state_e r_state;
    state_e w_state_d;

    logic        r_type;
    logic [23:0] r_color;
    logic [9:0]  r_x0;
    logic [9:0]  r_y0;
    logic [9:0]  r_x1;
    logic [9:0]  r_y1;
    logic [15:0] r_count;
    logic        r_err;

    logic        w_acc;
    logic        w_stall;
    logic [7:0]  w_opcode;
    logic [9:0]  w_x_clamp;
    logic [9:0]  w_y_clamp;
    logic        w_hdr_acc;
    logic        w_arg1_acc;
    logic        w_arg2_acc;

    // The stall only depends on the registered state, so the FIFO pointer moves
    // exactly once per accepted word.
    always_comb begin
        w_stall = 1'b1;
        unique case (r_state)
            StHeader, StArg1, StArg2: w_stall = 1'b0;
            default:                  w_stall = 1'b1;
        endcase
    end

    assign w_acc    = !w_stall && !fifo_stall;
    assign w_opcode = fifo_GP_out[31:24];

    // Clamp each coordinate of the incoming argument word.
    assign w_x_clamp = (fifo_GP_out[9:0]   > XMaxC) ? XMaxC : fifo_GP_out[9:0];
    assign w_y_clamp = (fifo_GP_out[25:16] > YMaxC) ? YMaxC : fifo_GP_out[25:16];

    // A GP_valid restart wins over any word accepted in the same cycle.
    assign w_hdr_acc  = w_acc && !GP_valid && (r_state == StHeader);
    assign w_arg1_acc = w_acc && !GP_valid && (r_state == StArg1);
    assign w_arg2_acc = w_acc && !GP_valid && (r_state == StArg2);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: w_state_d = StIdle;
            StHeader: begin
                if (w_acc) begin
                    if (w_opcode == OpFill || w_opcode == OpLine) begin
                        w_state_d = StArg1;
                    end else if (w_opcode == OpStop) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StErr;
                    end
                end
            end
            StArg1:  if (w_acc) w_state_d = StArg2;
            StArg2:  if (w_acc) w_state_d = StIssue;
            StIssue: if (cmd_ready) w_state_d = StHeader;
            StDone:  w_state_d = StIdle;
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (GP_valid) begin
            w_state_d = StHeader;
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        GP_stall     = w_stall;
        cmd_valid    = (r_state == StIssue);
        GP_interrupt = (r_state == StDone) || (r_state == StErr);
    end

    // Command fields, counter and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_type  <= 1'b0;
            r_color <= 24'd0;
            r_x0    <= 10'd0;
            r_y0    <= 10'd0;
            r_x1    <= 10'd0;
            r_y1    <= 10'd0;
            r_count <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_hdr_acc && (w_opcode == OpFill || w_opcode == OpLine)) begin
                r_type  <= (w_opcode == OpLine);
                r_color <= fifo_GP_out[23:0];
            end

            if (w_arg1_acc) begin
                r_x0 <= w_x_clamp;
                r_y0 <= w_y_clamp;
            end

            // FILL swaps each axis on its own so the rectangle is top-left first;
            // LINE keeps the endpoint order because it encodes the direction.
            if (w_arg2_acc) begin
                if (!r_type && (r_x0 > w_x_clamp)) begin
                    r_x0 <= w_x_clamp;
                    r_x1 <= r_x0;
                end else begin
                    r_x1 <= w_x_clamp;
                end
                if (!r_type && (r_y0 > w_y_clamp)) begin
                    r_y0 <= w_y_clamp;
                    r_y1 <= r_y0;
                end else begin
                    r_y1 <= w_y_clamp;
                end
            end

            if (GP_valid) begin
                r_count <= 16'd0;
            end else if ((r_state == StIssue) && cmd_ready) begin
                r_count <= r_count + 16'd1;
            end

            if (GP_valid) begin
                r_err <= 1'b0;
            end else if (w_hdr_acc && (w_opcode != OpStop) && (w_opcode != OpFill) &&
                         (w_opcode != OpLine)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cmd_type  = r_type;
    assign cmd_color = r_color;
    assign cmd_x0    = r_x0;
    assign cmd_y0    = r_y0;
    assign cmd_x1    = r_x1;
    assign cmd_y1    = r_y1;
    assign cmd_count = r_count;
    assign err       = r_err;

endmodule
